// File: rtl/param_cache.sv
// param_cache
//   Write-through, write-allocate, set-associative cache between one hart
//   port and a word-wide memory. Line size, set count and way count are
//   parameters. Replacement is per-set round-robin, preferring invalid ways.
//   Read hits return data combinationally. Misses and all writes stall the
//   hart through o_busy.
//
// Parameters
//   O  offset bits (line = 2**O bytes, D = 2**(O-2) words, O >= 2)
//   S  set-index bits (2**S sets)
//   W  ways per set (power of two, 1..8)
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_mem_ready       memory accepts the current ren/wen this cycle
//   o_mem_addr        word-aligned memory address
//   o_mem_ren/o_mem_wen  memory read / full-word write request
//   o_mem_wdata       memory write data
//   i_mem_rdata       memory read data, qualified by i_mem_valid
//   i_flush           invalidate every line (honoured only in IDLE with no request)
//   o_busy            stall to the hart
//   i_req_addr        word-aligned request address, held during a stall
//   i_req_ren/i_req_wen  read / write request (first cycle only)
//   i_req_mask        byte enables of a write
//   i_req_wdata       write data
//   o_res_rdata       read data of the hit word
module param_cache #(
  parameter int O = 4,
  parameter int S = 5,
  parameter int W = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  input  logic        i_flush,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata
);

  localparam int T     = 32 - O - S;
  localparam int D     = 2 ** (O - 2);
  localparam int NSETS = 2 ** S;
  localparam int KW    = (D > 1) ? $clog2(D) : 1;
  localparam int WB    = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, WRITE} state_t;

  state_t           state;
  logic [31:0]      data_mem [W][NSETS][D];
  logic [T-1:0]     tag_mem  [W][NSETS];
  logic [NSETS-1:0] valid_q  [W];
  logic [WB-1:0]    rr_q     [NSETS];

  logic [KW-1:0] k_q;
  logic [WB-1:0] way_q;
  logic          is_write_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;

  logic [T-1:0]  req_tag;
  logic [S-1:0]  req_index;
  logic [KW-1:0] req_word;
  logic [31:0]   line_base;
  logic          hit;
  logic [WB-1:0] hit_way;
  logic [WB-1:0] victim;
  logic          victim_found;
  logic          last_word;
  logic [31:0]   fill_src;

  assign req_tag   = T'(i_req_addr >> (O + S));
  assign req_index = S'(i_req_addr >> O);
  assign req_word  = KW'((i_req_addr >> 2) & 32'(D - 1));
  assign line_base = i_req_addr & ~32'((1 << O) - 1);
  assign last_word = (k_q == KW'(D - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < W; w++) begin
      if (valid_q[w][req_index] && (tag_mem[w][req_index] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // Lowest invalid way wins; the round-robin pointer only matters for a full set.
  always_comb begin
    victim       = rr_q[req_index];
    victim_found = 1'b0;
    for (int w = 0; w < W; w++) begin
      if (!victim_found && !valid_q[w][req_index]) begin
        victim       = WB'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign o_res_rdata = data_mem[hit_way][req_index][req_word];
  assign o_busy      = (state != IDLE) || i_req_wen || (i_req_ren && !hit);

  // When a write miss finishes its fill, the requested word may be the one
  // arriving this very cycle and not yet in the array.
  assign fill_src = (k_q == req_word) ? i_mem_rdata
                                      : data_mem[way_q][req_index][req_word];

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      k_q         <= '0;
      way_q       <= '0;
      is_write_q  <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      o_mem_ren   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      for (int w = 0; w < W; w++) valid_q[w] <= '0;
      for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_ren || i_req_wen) begin
            mask_q  <= i_req_mask;
            wdata_q <= i_req_wdata;
            if (!hit) begin
              // The victim is invalidated up front so an aborted fill never
              // leaves a half-written line looking valid.
              is_write_q                 <= i_req_wen;
              way_q                      <= victim;
              k_q                        <= '0;
              valid_q[victim][req_index] <= 1'b0;
              rr_q[req_index]            <= (rr_q[req_index] == WB'(W - 1)) ? '0
                                            : rr_q[req_index] + WB'(1);
              o_mem_ren                  <= 1'b1;
              o_mem_addr                 <= line_base;
              state                      <= FILL_REQ;
            end else if (i_req_wen) begin
              is_write_q  <= 1'b1;
              way_q       <= hit_way;
              o_mem_wen   <= 1'b1;
              o_mem_addr  <= i_req_addr;
              o_mem_wdata <= merge_word(o_res_rdata, i_req_wdata, i_req_mask);
              state       <= WRITE;
            end
          end else if (i_flush) begin
            for (int w = 0; w < W; w++) valid_q[w] <= '0;
          end
        end
        FILL_REQ: begin
          if (i_mem_ready) begin
            o_mem_ren <= 1'b0;
            state     <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (i_mem_valid) begin
            if (last_word) begin
              valid_q[way_q][req_index] <= 1'b1;
              if (is_write_q) begin
                o_mem_wen   <= 1'b1;
                o_mem_addr  <= i_req_addr;
                o_mem_wdata <= merge_word(fill_src, wdata_q, mask_q);
                state       <= WRITE;
              end else begin
                o_mem_addr <= '0;
                state      <= IDLE;
              end
            end else begin
              k_q        <= k_q + KW'(1);
              o_mem_ren  <= 1'b1;
              o_mem_addr <= line_base | ((32'(k_q) + 32'd1) << 2);
              state      <= FILL_REQ;
            end
          end
        end
        WRITE: begin
          if (i_mem_ready) begin
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage has no reset; valid bits alone decide what is usable.
  always_ff @(posedge i_clk) begin
    if (state == FILL_WAIT && i_mem_valid) begin
      data_mem[way_q][req_index][k_q] <= i_mem_rdata;
      if (last_word) tag_mem[way_q][req_index] <= req_tag;
    end
    if (state == WRITE && i_mem_ready)
      data_mem[way_q][req_index][req_word] <= o_mem_wdata;
  end

endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache
//   Self-checking bench for param_cache (O=4, S=5, W=2). A memory responder
//   with random ready and random read latency serves the cache; expectations
//   come from constant vectors and from a behavioural model of the cache
//   directory (valid/tag per way, round-robin pointer per set) plus a word
//   memory model, which is also the golden source of read data because the
//   cache is write-through.
module tb_param_cache;

  localparam int O     = 4;
  localparam int S     = 5;
  localparam int W     = 2;
  localparam int D     = 4;
  localparam int NSETS = 32;

  logic        i_clk;
  logic        i_rst;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;
  logic        i_flush;
  logic        o_busy;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [3:0]  i_req_mask;
  logic [31:0] i_req_wdata;
  logic [31:0] o_res_rdata;

  param_cache #(.O(O), .S(S), .W(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mem_ready (i_mem_ready),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ren   (o_mem_ren),
    .o_mem_wen   (o_mem_wen),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_valid (i_mem_valid),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .i_req_addr  (i_req_addr),
    .i_req_ren   (i_req_ren),
    .i_req_wen   (i_req_wen),
    .i_req_mask  (i_req_mask),
    .i_req_wdata (i_req_wdata),
    .o_res_rdata (o_res_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory model: explicit words override an address-derived default.
  logic [31:0] mem_ov [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  // Memory responder: decisions are made at the falling edge for the next rising edge.
  bit          pend;
  int          pend_lat;
  logic [31:0] pend_addr;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [31:0] rd_addrs [$];
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          forced_lat = -1;

  initial begin
    i_mem_ready = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_rdata = '0;
    pend        = 1'b0;
    forever begin
      @(negedge i_clk);
      i_mem_valid = 1'b0;
      if (i_rst) pend = 1'b0;
      else if (pend) begin
        if (pend_lat == 0) begin
          i_mem_valid = 1'b1;
          i_mem_rdata = mem_read(pend_addr);
          pend        = 1'b0;
        end else pend_lat--;
      end
      i_mem_ready = ($urandom_range(0, 3) != 0);
      if (!i_rst && i_mem_ready && o_mem_ren) begin
        rd_count++;
        rd_addrs.push_back(o_mem_addr);
        pend      = 1'b1;
        pend_addr = o_mem_addr;
        pend_lat  = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 2));
      end
      if (!i_rst && i_mem_ready && o_mem_wen) begin
        wr_count++;
        last_wr_addr       = o_mem_addr;
        last_wr_data       = o_mem_wdata;
        mem_ov[o_mem_addr] = o_mem_wdata;
      end
    end
  end

  // Directory model of the cache.
  bit m_valid [W][NSETS];
  int m_tag   [W][NSETS];
  int m_rr    [NSETS];

  function automatic void model_reset();
    for (int w = 0; w < W; w++)
      for (int s = 0; s < NSETS; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < NSETS; s++) m_rr[s] = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int set = int'(a >> O) % NSETS;
    int tag = int'(a >> (O + S));
    for (int w = 0; w < W; w++)
      if (m_valid[w][set] && m_tag[w][set] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int set = int'(a >> O) % NSETS;
    int v   = -1;
    for (int w = 0; w < W; w++)
      if (v < 0 && !m_valid[w][set]) v = w;
    if (v < 0) v = m_rr[set];
    m_rr[set]     = (m_rr[set] + 1) % W;
    m_valid[v][set] = 1'b1;
    m_tag[v][set]   = int'(a >> (O + S));
  endfunction

  // One hart transaction: request in the first cycle, then wait for busy to drop.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] wdata, input bit flush,
                               output bit busy0, output logic [31:0] rdata,
                               output int nrd, output int nwr, output bit timed_out);
    int rd0 = rd_count;
    int wr0 = wr_count;
    int cyc = 0;
    rd_addrs.delete();
    @(negedge i_clk);
    i_req_addr  = addr;
    i_req_ren   = !wr;
    i_req_wen   = wr;
    i_req_mask  = mask;
    i_req_wdata = wdata;
    i_flush     = flush;
    #1 busy0 = o_busy;
    @(negedge i_clk);
    i_req_ren = 1'b0;
    i_req_wen = 1'b0;
    i_flush   = 1'b0;
    #1;
    while (o_busy && cyc < 400) begin
      @(negedge i_clk);
      #1 cyc++;
    end
    timed_out = o_busy;
    rdata     = o_res_rdata;
    nrd       = rd_count - rd0;
    nwr       = wr_count - wr0;
  endtask

  task automatic check_fill_addrs(input string name, input logic [31:0] addr);
    logic [31:0] base = addr & ~32'(D * 4 - 1);
    for (int k = 0; k < rd_addrs.size() && k < D; k++)
      checkOutput($sformatf("%s_fill_addr%0d", name, k), rd_addrs[k], base + 32'(4 * k));
  endtask

  // Model-driven transaction with full comparison.
  task automatic run_and_check(input string name, input bit wr, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] wdata);
    bit          busy0, tmo;
    logic [31:0] rdata;
    int          nrd, nwr;
    bit          exp_miss = !model_hit(addr);
    logic [31:0] exp_word = wr ? merge_ref(mem_read(addr), wdata, mask) : mem_read(addr);
    applyStimulus(wr, addr, mask, wdata, 1'b0, busy0, rdata, nrd, nwr, tmo);
    if (exp_miss) model_fill(addr);
    checkOutput({name, "_timeout"}, 32'(tmo), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy0), 32'(exp_miss || wr));
    checkOutput({name, "_reads"}, 32'(nrd), exp_miss ? 32'(D) : 32'd0);
    checkOutput({name, "_writes"}, 32'(nwr), wr ? 32'd1 : 32'd0);
    checkOutput({name, "_rdata"}, rdata, exp_word);
    if (exp_miss) check_fill_addrs(name, addr);
    if (wr) begin
      checkOutput({name, "_waddr"}, last_wr_addr, addr);
      checkOutput({name, "_wdata"}, last_wr_data, exp_word);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    bit          exp_busy;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    forever begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
    end
  end

  initial begin
    bit          busy0, tmo;
    logic [31:0] rdata;
    int          nrd, nwr, rd0, cyc;

    mem_ov[32'h100] = 32'hA0;
    mem_ov[32'h104] = 32'hA1;
    mem_ov[32'h108] = 32'hA2;
    mem_ov[32'h10C] = 32'hA3;

    vecs[0]  = '{1'b0, 32'h100, 4'h0, 32'h0,          1'b1, 4, 0, 32'h0000_00A0};
    vecs[1]  = '{1'b0, 32'h108, 4'h0, 32'h0,          1'b0, 0, 0, 32'h0000_00A2};
    vecs[2]  = '{1'b1, 32'h104, 4'h3, 32'h1234_5678,  1'b1, 0, 1, 32'h0000_5678};
    vecs[3]  = '{1'b0, 32'h104, 4'h0, 32'h0,          1'b0, 0, 0, 32'h0000_5678};
    vecs[4]  = '{1'b0, 32'h000, 4'h0, 32'h0,          1'b1, 4, 0, 32'h5A5A_0000};
    vecs[5]  = '{1'b0, 32'h200, 4'h0, 32'h0,          1'b1, 4, 0, 32'h5A5A_0200};
    vecs[6]  = '{1'b0, 32'h400, 4'h0, 32'h0,          1'b1, 4, 0, 32'h5A5A_0400};
    vecs[7]  = '{1'b0, 32'h200, 4'h0, 32'h0,          1'b0, 0, 0, 32'h5A5A_0200};
    vecs[8]  = '{1'b0, 32'h000, 4'h0, 32'h0,          1'b1, 4, 0, 32'h5A5A_0000};
    vecs[9]  = '{1'b0, 32'h400, 4'h0, 32'h0,          1'b0, 0, 0, 32'h5A5A_0400};
    vecs[10] = '{1'b0, 32'h200, 4'h0, 32'h0,          1'b1, 4, 0, 32'h5A5A_0200};

    i_rst       = 1'b1;
    i_flush     = 1'b0;
    i_req_addr  = '0;
    i_req_ren   = 1'b0;
    i_req_wen   = 1'b0;
    i_req_mask  = '0;
    i_req_wdata = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("reset_busy",  32'(o_busy), 32'd0);
    checkOutput("reset_ren",   32'(o_mem_ren), 32'd0);
    checkOutput("reset_wen",   32'(o_mem_wen), 32'd0);
    checkOutput("reset_addr",  o_mem_addr, 32'd0);
    checkOutput("reset_wdata", o_mem_wdata, 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].wdata, 1'b0,
                    busy0, rdata, nrd, nwr, tmo);
      checkOutput($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_reads", i), 32'(nrd), 32'(vecs[i].exp_reads));
      checkOutput($sformatf("vec%0d_writes", i), 32'(nwr), 32'(vecs[i].exp_writes));
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_reads == D) check_fill_addrs($sformatf("vec%0d", i), vecs[i].addr);
      if (vecs[i].wr) begin
        checkOutput($sformatf("vec%0d_waddr", i), last_wr_addr, vecs[i].addr);
        checkOutput($sformatf("vec%0d_wdata", i), last_wr_data, vecs[i].exp_rdata);
      end
    end

    $display("[TB] flush");
    @(negedge i_clk);
    i_flush = 1'b1;
    #1 checkOutput("flush_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, busy0, rdata, nrd, nwr, tmo);
    checkOutput("postflush_busy", 32'(busy0), 32'd1);
    checkOutput("postflush_reads", 32'(nrd), 32'(D));
    checkOutput("postflush_rdata", rdata, 32'h0000_00A0);
    check_fill_addrs("postflush", 32'h100);
    applyStimulus(1'b0, 32'h104, 4'h0, 32'h0, 1'b1, busy0, rdata, nrd, nwr, tmo);
    checkOutput("flushren_busy", 32'(busy0), 32'd0);
    checkOutput("flushren_rdata", rdata, 32'h0000_5678);
    applyStimulus(1'b0, 32'h108, 4'h0, 32'h0, 1'b0, busy0, rdata, nrd, nwr, tmo);
    checkOutput("flushren_kept_busy", 32'(busy0), 32'd0);
    checkOutput("flushren_kept_reads", 32'(nrd), 32'd0);

    $display("[TB] reset during fill");
    forced_lat = 6;
    rd0 = rd_count;
    @(negedge i_clk);
    i_req_addr = 32'h300;
    i_req_ren  = 1'b1;
    @(negedge i_clk);
    i_req_ren = 1'b0;
    cyc = 0;
    #2;
    while (rd_count - rd0 < 3 && cyc < 200) begin
      @(negedge i_clk);
      #2 cyc++;
    end
    checkOutput("midfill_third_read", 32'(rd_count - rd0), 32'd3);
    @(posedge i_clk);
    #1 checkOutput("midfill_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    checkOutput("midfill_rst_busy",  32'(o_busy), 32'd0);
    checkOutput("midfill_rst_ren",   32'(o_mem_ren), 32'd0);
    checkOutput("midfill_rst_wen",   32'(o_mem_wen), 32'd0);
    checkOutput("midfill_rst_addr",  o_mem_addr, 32'd0);
    checkOutput("midfill_rst_wdata", o_mem_wdata, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst      = 1'b0;
    forced_lat = -1;
    model_reset();
    run_and_check("postrst_300", 1'b0, 32'h300, 4'h0, 32'h0);
    run_and_check("postrst_100", 1'b0, 32'h100, 4'h0, 32'h0);

    $display("[TB] random traffic against model");
    for (int n = 0; n < 250; n++) begin
      int          r     = int'($urandom_range(0, 9));
      logic [31:0] addr  = (32'($urandom_range(0, 3)) << (O + S)) |
                           (32'($urandom_range(0, 1)) << O) |
                           (32'($urandom_range(0, D - 1)) << 2);
      if (r < 6) begin
        run_and_check($sformatf("rnd%0d_rd", n), 1'b0, addr, 4'h0, 32'h0);
      end else if (r < 9) begin
        run_and_check($sformatf("rnd%0d_wr", n), 1'b1, addr, 4'($urandom_range(0, 15)),
                      $urandom);
      end else begin
        @(negedge i_clk);
        i_flush = 1'b1;
        #1 checkOutput($sformatf("rnd%0d_flush_busy", n), 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_flush = 1'b0;
        model_reset_valid_only();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // A flush leaves the round-robin pointers alone.
  function automatic void model_reset_valid_only();
    for (int w = 0; w < W; w++)
      for (int s = 0; s < NSETS; s++) m_valid[w][s] = 1'b0;
  endfunction

endmodule
